// File: rtl/imm_extend_pipe.sv
// Pipelined ARMv8 immediate generator: extracts I/D/B/CB/MOVZ fields, extends them to
// DATA_W bits and holds the results in a 2-entry head/skid buffer with valid/ready handshakes.
module imm_extend_pipe #(
   parameter int DATA_W   = 64,
   parameter bit SHIFT_BR = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [2:0]        mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm,
   output logic              imm_err
);

   localparam logic [2:0] MODE_I    = 3'd0;
   localparam logic [2:0] MODE_D    = 3'd1;
   localparam logic [2:0] MODE_B    = 3'd2;
   localparam logic [2:0] MODE_CB   = 3'd3;
   localparam logic [2:0] MODE_MOVZ = 3'd4;

   logic [DATA_W-1:0] extImm;
   logic              extErr;
   logic [DATA_W-1:0] brImm;
   logic [DATA_W-1:0] cbImm;
   logic [1:0]        movzHw;

   logic              headValid;
   logic [DATA_W-1:0] headImm;
   logic              headErr;
   logic              skidValid;
   logic [DATA_W-1:0] skidImm;
   logic              skidErr;

   logic              accept;
   logic              drain;

   assign brImm  = {{(DATA_W-26){instr[25]}}, instr[25:0]};
   assign cbImm  = {{(DATA_W-19){instr[23]}}, instr[23:5]};
   assign movzHw = instr[22:21];

   always_comb begin
      extImm = '0;
      extErr = 1'b0;
      case (mode)
         MODE_I:  extImm = {{(DATA_W-12){1'b0}}, instr[21:10]};
         MODE_D:  extImm = {{(DATA_W-9){instr[20]}}, instr[20:12]};
         MODE_B:  extImm = SHIFT_BR ? (brImm << 2) : brImm;
         MODE_CB: extImm = SHIFT_BR ? (cbImm << 2) : cbImm;
         MODE_MOVZ: begin
            // A halfword slot that lies beyond the output width cannot be encoded.
            if ((int'(movzHw) + 1) * 16 > DATA_W) begin
               extErr = 1'b1;
            end else begin
               extImm = {{(DATA_W-16){1'b0}}, instr[20:5]} << {movzHw, 4'b0000};
            end
         end
         default: extErr = 1'b1;
      endcase
   end

   // in_ready depends only on skid occupancy, so there is no path from out_ready.
   assign in_ready  = !skidValid;
   assign out_valid = headValid;
   assign imm       = headImm;
   assign imm_err   = headErr;

   assign accept = in_valid && in_ready;
   assign drain  = headValid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         headValid <= 1'b0;
         headImm   <= '0;
         headErr   <= 1'b0;
         skidValid <= 1'b0;
         skidImm   <= '0;
         skidErr   <= 1'b0;
      end else if (flush) begin
         headValid <= 1'b0;
         skidValid <= 1'b0;
      end else if (skidValid) begin
         if (drain) begin
            headImm   <= skidImm;
            headErr   <= skidErr;
            skidValid <= 1'b0;
         end
      end else if (headValid) begin
         if (accept && drain) begin
            headImm <= extImm;
            headErr <= extErr;
         end else if (accept) begin
            skidImm   <= extImm;
            skidErr   <= extErr;
            skidValid <= 1'b1;
         end else if (drain) begin
            headValid <= 1'b0;
         end
      end else if (accept) begin
         headImm   <= extImm;
         headErr   <= extErr;
         headValid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three configurations share one stimulus stream; directed vector table,
// backpressure/flush/reset sequences and a random stream checked against a reference model.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] instr;
   logic [2:0]  mode;
   logic        out_ready;

   logic        inReady64, outValid64, immErr64;
   logic [63:0] imm64;
   logic        inReady32, outValid32, immErr32;
   logic [31:0] imm32;
   logic        inReadyNs, outValidNs, immErrNs;
   logic [63:0] immNs;

   int nChecks = 0;
   int nErrors = 0;
   bit sbOn    = 1'b0;

   localparam logic [64:0] ERR = {1'b1, 64'h0};

   typedef struct {
      logic [2:0]  mode;
      logic [31:0] instr;
      logic [64:0] x64;
      logic [64:0] x32;
      logic [64:0] xNs;
   } vec_t;

   typedef struct {
      logic [64:0] e64;
      logic [64:0] e32;
      logic [64:0] eNs;
   } exp_t;

   vec_t vecs[14];
   exp_t sbQ[$];

   imm_extend_pipe #(.DATA_W(64), .SHIFT_BR(1'b1)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady64),
      .instr(instr), .mode(mode), .out_valid(outValid64), .out_ready(out_ready),
      .imm(imm64), .imm_err(immErr64));

   imm_extend_pipe #(.DATA_W(32), .SHIFT_BR(1'b1)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady32),
      .instr(instr), .mode(mode), .out_valid(outValid32), .out_ready(out_ready),
      .imm(imm32), .imm_err(immErr32));

   imm_extend_pipe #(.DATA_W(64), .SHIFT_BR(1'b0)) dutNs (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReadyNs),
      .instr(instr), .mode(mode), .out_valid(outValidNs), .out_ready(out_ready),
      .imm(immNs), .imm_err(immErrNs));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference extraction written arithmetically; result is {err, imm masked to dw bits}.
   function automatic logic [64:0] model(input int dw, input bit sh, input logic [2:0] m,
                                         input logic [31:0] ins);
      longint v;
      int     hw;
      v = 0;
      case (m)
         3'd0: v = longint'(ins[21:10]);
         3'd1: v = longint'($signed(ins[20:12]));
         3'd2: v = longint'($signed(ins[25:0])) * (sh ? 4 : 1);
         3'd3: v = longint'($signed(ins[23:5])) * (sh ? 4 : 1);
         3'd4: begin
            hw = int'(ins[22:21]);
            if (16 * hw + 16 > dw) return ERR;
            v = longint'(ins[20:5]) << (16 * hw);
         end
         default: return ERR;
      endcase
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return {1'b0, 64'(v)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushI(input logic [11:0] v);
      in_valid = 1'b1;
      mode     = 3'd0;
      instr    = {10'h0, v, 10'h0};
      step();
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sbOn && rst_n && !flush) begin
         if (in_valid && inReady64)
            sbQ.push_back('{model(64, 1'b1, mode, instr), model(32, 1'b1, mode, instr),
                            model(64, 1'b0, mode, instr)});
         if (outValid64 && out_ready) begin
            if (sbQ.size() == 0) begin
               chk("sb_unexpected_output", {1'b0, imm64}, 65'h0);
            end else begin
               exp_t e;
               e = sbQ.pop_front();
               chk("sb_imm64", {immErr64, imm64}, e.e64);
               chk("sb_imm32", {immErr32, 32'h0, imm32}, e.e32);
               chk("sb_immNs", {immErrNs, immNs}, e.eNs);
               chk("sb_valid_agree", {63'h0, outValid32, outValidNs}, 65'h3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{3'd0, 32'h91003C20, 65'hF, 65'hF, 65'hF};
      vecs[1]  = '{3'd1, 32'hF8500000, 65'h0_FFFFFFFFFFFFFF00, 65'h0_00000000FFFFFF00, 65'h0_FFFFFFFFFFFFFF00};
      vecs[2]  = '{3'd2, 32'h17FFFFFF, 65'h0_FFFFFFFFFFFFFFFC, 65'h0_00000000FFFFFFFC, 65'h0_FFFFFFFFFFFFFFFF};
      vecs[3]  = '{3'd3, 32'hB4000040, 65'h8, 65'h8, 65'h2};
      vecs[4]  = '{3'd4, 32'hD2A00020, 65'h10000, 65'h10000, 65'h10000};
      vecs[5]  = '{3'd4, 32'hD2C00020, 65'h1_00000000, ERR, 65'h1_00000000};
      vecs[6]  = '{3'd6, 32'h12345678, ERR, ERR, ERR};
      vecs[7]  = '{3'd4, 32'hD2FFFFE0, 65'h0_FFFF000000000000, ERR, 65'h0_FFFF000000000000};
      vecs[8]  = '{3'd2, 32'h15FFFFFF, 65'h7FFFFFC, 65'h7FFFFFC, 65'h1FFFFFF};
      vecs[9]  = '{3'd3, 32'hB4FFFFE0, 65'h0_FFFFFFFFFFFFFFFC, 65'h0_00000000FFFFFFFC, 65'h0_FFFFFFFFFFFFFFFF};
      vecs[10] = '{3'd0, 32'h913FFC00, 65'hFFF, 65'hFFF, 65'hFFF};
      vecs[11] = '{3'd5, 32'hFFFFFFFF, ERR, ERR, ERR};
      vecs[12] = '{3'd7, 32'h00000000, ERR, ERR, ERR};
      vecs[13] = '{3'd4, 32'hD29FFFE0, 65'hFFFF, 65'hFFFF, 65'hFFFF};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; mode = '0; out_ready = 1'b0;
      repeat (2) step();
      chk("reset_out_valid", {64'h0, outValid64}, 65'h0);
      chk("reset_in_ready", {64'h0, inReady64}, 65'h1);
      chk("reset_imm", {immErr64, imm64}, 65'h0);
      rst_n = 1'b1;
      step();

      // Back-to-back vectors: each is visible one cycle after acceptance, 1 per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1;
         mode     = vecs[i].mode;
         instr    = vecs[i].instr;
         step();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), {62'h0, outValid64, outValid32, outValidNs}, 65'h7);
         chk($sformatf("vec%0d_w64", i), {immErr64, imm64}, vecs[i].x64);
         chk($sformatf("vec%0d_w32", i), {immErr32, 32'h0, imm32}, vecs[i].x32);
         chk($sformatf("vec%0d_noshift", i), {immErrNs, immNs}, vecs[i].xNs);
      end
      step();
      chk("vec_drained", {64'h0, outValid64}, 65'h0);

      // Backpressure: third input held off while two entries are stalled.
      out_ready = 1'b0;
      pushI(12'd1);
      chk("bp_first_head", {outValid64, imm64}, {1'b1, 64'd1});
      chk("bp_ready_after_1", {64'h0, inReady64}, 65'h1);
      pushI(12'd2);
      chk("bp_ready_after_2", {64'h0, inReady64}, 65'h0);
      in_valid = 1'b1;
      instr    = {10'h0, 12'd3, 10'h0};
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_stall_head", {outValid64, imm64}, {1'b1, 64'd1});
         chk("bp_stall_ready", {64'h0, inReady64}, 65'h0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_second", {outValid64, imm64}, {1'b1, 64'd2});
      chk("bp_ready_reopen", {64'h0, inReady64}, 65'h1);
      step();
      in_valid = 1'b0;
      chk("bp_third", {outValid64, imm64}, {1'b1, 64'd3});
      step();
      chk("bp_empty", {64'h0, outValid64}, 65'h0);

      // Flush with two entries buffered plus a new input in the flush cycle.
      out_ready = 1'b0;
      pushI(12'd5);
      pushI(12'd6);
      in_valid = 1'b1;
      instr    = {10'h0, 12'd7, 10'h0};
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {64'h0, outValid64}, 65'h0);
      chk("flush_in_ready", {64'h0, inReady64}, 65'h1);
      out_ready = 1'b1;
      repeat (2) step();
      chk("flush_no_output", {64'h0, outValid64}, 65'h0);

      // Same again with reset, which also clears the immediate.
      out_ready = 1'b0;
      pushI(12'd8);
      pushI(12'd9);
      in_valid = 1'b1;
      instr    = {10'h0, 12'd10, 10'h0};
      rst_n    = 1'b0;
      flush    = 1'b1;
      step();
      rst_n    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("rst_out_valid", {64'h0, outValid64}, 65'h0);
      chk("rst_in_ready", {64'h0, inReady64}, 65'h1);
      chk("rst_imm", {immErr64, imm64}, 65'h0);
      out_ready = 1'b1;
      repeat (2) step();
      chk("rst_no_output", {64'h0, outValid64}, 65'h0);

      // Random stream with random backpressure, checked by the scoreboard monitor.
      sbOn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bit accepted;
         int waitCyc;
         in_valid = 1'b1;
         mode     = 3'($urandom_range(0, 7));
         instr    = $urandom;
         accepted = 1'b0;
         waitCyc  = 0;
         while (!accepted && waitCyc < 50) begin
            out_ready = 1'($urandom_range(0, 1));
            accepted  = inReady64;
            step();
            waitCyc++;
         end
         if (!accepted) chk("stream_accept_timeout", 65'h0, 65'h1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sbQ.size() != 0; c++) step();
      chk("stream_all_drained", 65'(sbQ.size()), 65'h0);
      step();
      chk("stream_idle", {64'h0, outValid64}, 65'h0);
      sbOn = 1'b0;

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
